// File: rtl/ft601_fifo_master_pkg.sv
// ---------------------------------------------------------------------------
// ft601_fifo_master_pkg
// Shared types for the FT601 synchronous 245-FIFO bus master.
//   ft_state_e : bus master phases (idle, write burst, read turnaround,
//                read burst, read release, final release)
//   ft_dir_e   : direction of the most recent burst, used for round-robin
//                arbitration when both directions are pending
// ---------------------------------------------------------------------------
package ft601_fifo_master_pkg;

   typedef enum logic [2:0] {
      FT_IDLE   = 3'd0,
      FT_WR     = 3'd1,
      FT_RD_OE  = 3'd2,
      FT_RD     = 3'd3,
      FT_RD_END = 3'd4,
      FT_TURN   = 3'd5
   } ft_state_e;

   typedef enum logic {
      FT_DIR_RD = 1'b0,
      FT_DIR_WR = 1'b1
   } ft_dir_e;

endpackage

// File: rtl/ft601_fifo_master.sv
// ---------------------------------------------------------------------------
// ft601_fifo_master
// Synchronous 245-FIFO bus master for the FT601 USB3 bridge (ft_clk domain).
// Moves words from the A2F stream onto ft_data (writes to the chip) and from
// ft_data into the F2A stream (reads from the chip). Pad tristates are split:
// the top level drives ft_data/ft_be as (ft_data_oe ? o : 'z).
//
// Ports
//   clk, reset            ft_clk and synchronous active-high reset
//   ft_txe_n, ft_rxf_n    chip TX-not-full / RX-not-empty flags (active low)
//   ft_oe_n/rd_n/wr_n     chip output enable, read and write strobes
//   ft_data_i/o, ft_be_i/o, ft_data_oe   bus sample, drive value, drive enable
//   tx_data/valid/ready   A2F show-ahead head word; tx_ready pops it
//   rx_data/be/wr         F2A push port (registered)
//   rx_afull              F2A has fewer than 4 free words
//   tx_words, rx_words    wrapping word counters per direction
// ---------------------------------------------------------------------------
module ft601_fifo_master
   import ft601_fifo_master_pkg::*;
#(
   parameter int DW        = 32,
   parameter int MAX_BURST = 32,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ft_txe_n,
   input  logic              ft_rxf_n,
   output logic              ft_oe_n,
   output logic              ft_rd_n,
   output logic              ft_wr_n,
   input  logic [DW-1:0]     ft_data_i,
   output logic [DW-1:0]     ft_data_o,
   output logic              ft_data_oe,
   input  logic [DW/8-1:0]   ft_be_i,
   output logic [DW/8-1:0]   ft_be_o,
   input  logic [DW-1:0]     tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DW-1:0]     rx_data,
   output logic [DW/8-1:0]   rx_be,
   output logic              rx_wr,
   input  logic              rx_afull,
   output logic [CNT_W-1:0]  tx_words,
   output logic [CNT_W-1:0]  rx_words
);

   localparam int BW   = DW / 8;
   localparam int BC_W = $clog2(MAX_BURST) + 1;
   localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_BURST);

   ft_state_e         state_q, state_d;
   ft_dir_e           last_dir_q, last_dir_d;
   logic [BC_W-1:0]   burst_q, burst_d;
   logic [BC_W-1:0]   burst_inc;
   logic [CNT_W-1:0]  tx_words_q, tx_words_d;
   logic [CNT_W-1:0]  rx_words_q, rx_words_d;
   logic [DW-1:0]     rx_data_q, rx_data_d;
   logic [BW-1:0]     rx_be_q, rx_be_d;
   logic              rx_wr_q, rx_wr_d;
   logic              wr_req;
   logic              rd_req;

   // The write data path is a straight feed of the A2F head word; it only
   // reaches the pads while ft_data_oe is high.
   assign ft_data_o = tx_data;
   assign ft_be_o   = '1;

   assign rx_data  = rx_data_q;
   assign rx_be    = rx_be_q;
   assign rx_wr    = rx_wr_q;
   assign tx_words = tx_words_q;
   assign rx_words = rx_words_q;

   always_comb begin
      state_d    = state_q;
      last_dir_d = last_dir_q;
      burst_d    = burst_q;
      tx_words_d = tx_words_q;
      rx_words_d = rx_words_q;
      rx_data_d  = rx_data_q;
      rx_be_d    = rx_be_q;
      rx_wr_d    = 1'b0;
      ft_oe_n    = 1'b1;
      ft_rd_n    = 1'b1;
      ft_wr_n    = 1'b1;
      ft_data_oe = 1'b0;
      tx_ready   = 1'b0;
      wr_req     = tx_valid & ~ft_txe_n;
      rd_req     = ~ft_rxf_n & ~rx_afull;
      burst_inc  = burst_q + BC_W'(1);

      unique case (state_q)
         FT_IDLE: begin
            // Round robin: with both sides pending, go opposite last burst.
            if (wr_req && (!rd_req || last_dir_q == FT_DIR_RD)) begin
               state_d = FT_WR;
            end else if (rd_req) begin
               state_d = FT_RD_OE;
            end
         end

         FT_WR: begin
            ft_data_oe = 1'b1;
            ft_wr_n    = ~tx_valid;
            tx_ready   = wr_req;
            last_dir_d = FT_DIR_WR;
            if (wr_req) begin
               tx_words_d = tx_words_q + CNT_W'(1);
               burst_d    = burst_inc;
            end
            // A txe_n rise drops tx_ready in the same cycle, so the word
            // stays at the A2F head and is retried in a later burst.
            if (!wr_req || burst_inc == BURST_MAX) begin
               state_d = FT_TURN;
            end
         end

         FT_RD_OE: begin
            // Chip takes the bus one cycle before the first read strobe.
            ft_oe_n = 1'b0;
            state_d = FT_RD;
         end

         FT_RD: begin
            ft_oe_n    = 1'b0;
            ft_rd_n    = 1'b0;
            last_dir_d = FT_DIR_RD;
            if (!ft_rxf_n) begin
               rx_data_d  = ft_data_i;
               rx_be_d    = ft_be_i;
               rx_wr_d    = 1'b1;
               rx_words_d = rx_words_q + CNT_W'(1);
               burst_d    = burst_inc;
            end
            // A word captured on the exit edge with rx_afull already high is
            // still pushed; the F2A free-word margin absorbs it.
            if (ft_rxf_n || rx_afull || burst_inc == BURST_MAX) begin
               state_d = FT_RD_END;
            end
         end

         FT_RD_END: begin
            state_d = FT_TURN;
         end

         FT_TURN: begin
            burst_d = '0;
            state_d = FT_IDLE;
         end

         default: begin
            state_d = FT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FT_IDLE;
         last_dir_q <= FT_DIR_RD;
         burst_q    <= '0;
         tx_words_q <= '0;
         rx_words_q <= '0;
         rx_data_q  <= '0;
         rx_be_q    <= '0;
         rx_wr_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_dir_q <= last_dir_d;
         burst_q    <= burst_d;
         tx_words_q <= tx_words_d;
         rx_words_q <= rx_words_d;
         rx_data_q  <= rx_data_d;
         rx_be_q    <= rx_be_d;
         rx_wr_q    <= rx_wr_d;
      end
   end

endmodule

// File: tb/tb_ft601_fifo_master.sv
// ---------------------------------------------------------------------------
// tb_ft601_fifo_master
// Bench for ft601_fifo_master. The environment models the A2F FIFO and the
// FT601 chip as queues: a word leaves the A2F queue exactly when the chip
// accepts it (wr_n and txe_n low while the FPGA drives), and a word leaves
// the chip queue when rd_n, oe_n and rxf_n are low; that word must then
// appear on the F2A push port one cycle later. Bus-ownership rules are
// checked every cycle, and each directed scenario pins a few literal values.
// ---------------------------------------------------------------------------
module tb_ft601_fifo_master;

   logic        clk;
   logic        reset;
   logic        ft_txe_n;
   logic        ft_rxf_n;
   logic        ft_oe_n;
   logic        ft_rd_n;
   logic        ft_wr_n;
   logic [31:0] ft_data_i;
   logic [31:0] ft_data_o;
   logic        ft_data_oe;
   logic [3:0]  ft_be_i;
   logic [3:0]  ft_be_o;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [31:0] rx_data;
   logic [3:0]  rx_be;
   logic        rx_wr;
   logic        rx_afull;
   logic [31:0] tx_words;
   logic [31:0] rx_words;

   ft601_fifo_master #(
      .DW        (32),
      .MAX_BURST (32),
      .CNT_W     (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ft_txe_n   (ft_txe_n),
      .ft_rxf_n   (ft_rxf_n),
      .ft_oe_n    (ft_oe_n),
      .ft_rd_n    (ft_rd_n),
      .ft_wr_n    (ft_wr_n),
      .ft_data_i  (ft_data_i),
      .ft_data_o  (ft_data_o),
      .ft_data_oe (ft_data_oe),
      .ft_be_i    (ft_be_i),
      .ft_be_o    (ft_be_o),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_be      (rx_be),
      .rx_wr      (rx_wr),
      .rx_afull   (rx_afull),
      .tx_words   (tx_words),
      .rx_words   (rx_words)
   );

   // Model state
   logic [31:0] txq[$];        // A2F contents, head first
   logic [35:0] chipq[$];      // FT601 RX contents {be, data}
   int          mdl_tx = 0;
   int          mdl_rx = 0;
   int          cyc = 0;
   int          wr_cyc[$];
   int          rd_cyc[$];
   int          oe_fall_cyc = 0;
   int          n_push = 0;

   // Scenario controls
   bit          rst_force = 1'b1;
   bit          chk_en = 1'b0;
   int          afull_at = -1;
   int          txe_at = -1;

   int          n_cmp = 0;
   int          n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic drive_inputs();
      tx_valid  = rst_force || (txq.size() > 0);
      tx_data   = (txq.size() > 0) ? txq[0] : 32'h0;
      ft_rxf_n  = !(rst_force || (chipq.size() > 0));
      {ft_be_i, ft_data_i} = (chipq.size() > 0) ? chipq[0] : 36'h0;
      ft_txe_n  = (txe_at >= 0) && (mdl_tx >= txe_at);
      rx_afull  = (afull_at >= 0) && (mdl_rx >= afull_at);
   endtask

   // Environment and per-cycle compare process
   initial begin : env
      bit          wacc;
      bit          racc;
      bit          prev_racc;
      bit          prev_oe_low;
      bit          prev_doe;
      logic [35:0] last_word;
      prev_racc   = 1'b0;
      prev_oe_low = 1'b0;
      prev_doe    = 1'b0;
      last_word   = '0;
      drive_inputs();
      forever begin
         @(negedge clk);
         wacc = 1'b0;
         racc = 1'b0;
         if (chk_en) begin
            wacc = (ft_wr_n === 1'b0) && (ft_txe_n === 1'b0) && (ft_data_oe === 1'b1);
            racc = (ft_rd_n === 1'b0) && (ft_oe_n === 1'b0) && (ft_rxf_n === 1'b0);
            chk("tx_ready", 64'(tx_ready), 64'(wacc));
            if (wacc) begin
               if (txq.size() > 0) begin
                  chk("wr_data", 64'(ft_data_o), 64'(txq[0]));
               end else begin
                  chk("wr_from_empty", 64'(1), 64'(0));
               end
               chk("wr_be", 64'(ft_be_o), 64'(4'hF));
               wr_cyc.push_back(cyc);
            end
            if (racc) rd_cyc.push_back(cyc);
            chk("rx_wr", 64'(rx_wr), 64'(prev_racc));
            if (prev_racc) begin
               chk("rx_data", 64'(rx_data), 64'(last_word[31:0]));
               chk("rx_be", 64'(rx_be), 64'(last_word[35:32]));
            end
            if (rx_wr === 1'b1) n_push++;
            chk("tx_words", 64'(tx_words), 64'(mdl_tx));
            chk("rx_words", 64'(rx_words), 64'(mdl_rx));
            chk("oe_with_drive", 64'((ft_oe_n === 1'b0) && (ft_data_oe === 1'b1)), 64'(0));
            chk("wr_without_drive", 64'((ft_wr_n === 1'b0) && (ft_data_oe !== 1'b1)), 64'(0));
            chk("rd_before_oe", 64'((ft_rd_n === 1'b0) && !prev_oe_low), 64'(0));
            chk("no_release_gap",
                64'(((ft_data_oe === 1'b1) && prev_oe_low) || ((ft_oe_n === 1'b0) && prev_doe)), 64'(0));
            if (!prev_oe_low && (ft_oe_n === 1'b0)) oe_fall_cyc = cyc;
            prev_oe_low = (ft_oe_n === 1'b0);
            prev_doe    = (ft_data_oe === 1'b1);
         end
         @(posedge clk);
         cyc++;
         #1;
         if (reset) begin
            mdl_tx    = 0;
            mdl_rx    = 0;
            prev_racc = 1'b0;
         end else begin
            if (wacc && txq.size() > 0) begin
               void'(txq.pop_front());
               mdl_tx++;
            end
            if (racc && chipq.size() > 0) begin
               last_word = chipq.pop_front();
               mdl_rx++;
            end
            prev_racc = racc;
         end
         drive_inputs();
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic wait_drain(input string name, input int maxc);
      int k;
      k = 0;
      while ((txq.size() > 0 || chipq.size() > 0) && k < maxc) begin
         step(1);
         k++;
      end
      chk(name, 64'(k < maxc), 64'(1));
      step(4);
   endtask

   initial begin : main
      int k;
      int np;
      reset = 1'b1;

      // 1: reset with both sides requesting
      step(1);
      chk_en = 1'b1;
      step(2);
      chk("rst_oe_n", 64'(ft_oe_n), 64'(1));
      chk("rst_rd_n", 64'(ft_rd_n), 64'(1));
      chk("rst_wr_n", 64'(ft_wr_n), 64'(1));
      chk("rst_data_oe", 64'(ft_data_oe), 64'(0));
      chk("rst_rx_wr", 64'(rx_wr), 64'(0));
      chk("rst_tx_words", 64'(tx_words), 64'(0));
      chk("rst_rx_words", 64'(rx_words), 64'(0));
      rst_force = 1'b0;
      step(2);
      reset = 1'b0;
      step(2);
      $display("scenario reset: done");

      // 2: 40-word write, split at the 32-word burst limit
      wr_cyc.delete();
      for (int i = 0; i < 40; i++) txq.push_back(32'hA500_0000 + 32'(i));
      wait_drain("t2_timeout", 300);
      chk("t2_write_count", 64'(wr_cyc.size()), 64'(40));
      if (wr_cyc.size() == 40) begin
         chk("t2_burst1_span", 64'(wr_cyc[31] - wr_cyc[0]), 64'(31));
         chk("t2_burst_gap", 64'(wr_cyc[32] - wr_cyc[31]), 64'(3));
         chk("t2_burst2_span", 64'(wr_cyc[39] - wr_cyc[32]), 64'(7));
      end
      chk("t2_tx_words", 64'(tx_words), 64'(40));
      $display("scenario write40: writes=%0d tx_words=%0d", wr_cyc.size(), tx_words);

      // 3: 10-word read with varying byte enables
      rd_cyc.delete();
      n_push = 0;
      for (int i = 0; i < 10; i++) chipq.push_back({4'hF >> (i % 4), 32'hC0DE_0000 | 32'(i)});
      wait_drain("t3_timeout", 300);
      chk("t3_read_count", 64'(rd_cyc.size()), 64'(10));
      if (rd_cyc.size() == 10) begin
         chk("t3_read_span", 64'(rd_cyc[9] - rd_cyc[0]), 64'(9));
         chk("t3_oe_lead", 64'(rd_cyc[0] - oe_fall_cyc), 64'(1));
      end
      chk("t3_pushes", 64'(n_push), 64'(10));
      chk("t3_rx_words", 64'(rx_words), 64'(10));
      chk("t3_last_data", 64'(rx_data), 64'(32'hC0DE_0009));
      chk("t3_last_be", 64'(rx_be), 64'(4'h7));
      $display("scenario read10: pushes=%0d rx_words=%0d", n_push, rx_words);

      // 4: F2A almost-full after the 5th word of a 12-word read
      n_push = 0;
      afull_at = mdl_rx + 5;
      for (int i = 0; i < 12; i++) chipq.push_back({4'hF, 32'hBEEF_0000 | 32'(i)});
      k = 0;
      while (rx_afull !== 1'b1 && k < 100) begin
         step(1);
         k++;
      end
      chk("t4_afull_timeout", 64'(k < 100), 64'(1));
      step(4);
      np = n_push;
      chk("t4_pushes_le6", 64'(np <= 6), 64'(1));
      chk("t4_pushes_ge5", 64'(np >= 5), 64'(1));
      step(10);
      chk("t4_hold_while_afull", 64'(n_push), 64'(np));
      afull_at = -1;
      wait_drain("t4_timeout", 300);
      chk("t4_pushes_total", 64'(n_push), 64'(12));
      chk("t4_rx_words", 64'(rx_words), 64'(22));
      $display("scenario afull: pushes_before_release=%0d rx_words=%0d", np, rx_words);

      // 5: both directions pending after a read burst -> write goes first
      wr_cyc.delete();
      rd_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         txq.push_back(32'h7700_0000 + 32'(i));
         chipq.push_back({4'h1, 32'h3300_0000 | 32'(i)});
      end
      wait_drain("t5_timeout", 300);
      chk("t5_writes", 64'(wr_cyc.size()), 64'(3));
      chk("t5_reads", 64'(rd_cyc.size()), 64'(3));
      if (wr_cyc.size() > 0 && rd_cyc.size() > 0) begin
         chk("t5_write_first", 64'(wr_cyc[0] < rd_cyc[0]), 64'(1));
      end
      chk("t5_tx_words", 64'(tx_words), 64'(43));
      chk("t5_rx_words", 64'(rx_words), 64'(25));
      $display("scenario arbitrate: tx_words=%0d rx_words=%0d", tx_words, rx_words);

      // 6: chip TX FIFO fills after word 7 of 12, then frees up
      wr_cyc.delete();
      txe_at = mdl_tx + 7;
      for (int i = 0; i < 12; i++) txq.push_back(32'h6600_0000 + 32'(i));
      k = 0;
      while (ft_txe_n !== 1'b1 && k < 100) begin
         step(1);
         k++;
      end
      chk("t6_txe_timeout", 64'(k < 100), 64'(1));
      step(10);
      chk("t6_pops_before", 64'(wr_cyc.size()), 64'(7));
      chk("t6_left_queued", 64'(txq.size()), 64'(5));
      chk("t6_tx_words_mid", 64'(tx_words), 64'(50));
      txe_at = -1;
      wait_drain("t6_timeout", 300);
      chk("t6_pops_total", 64'(wr_cyc.size()), 64'(12));
      chk("t6_tx_words", 64'(tx_words), 64'(55));
      $display("scenario txe_stall: writes=%0d tx_words=%0d", wr_cyc.size(), tx_words);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
